// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// jump opcodes, the default reset PC and the pseudo-direct jump-target helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } ifu_state_e;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_JAL           = 6'b000011;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // j/jal target: keep the region bits of PC+4, splice in the word index
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] instr_index);
        return {pc_plus4[31:28], instr_index, 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_unit_npc_sel.sv
// Next-PC selector: jr beats j/jal, which beat a taken conditional branch;
// otherwise sequential. The result is always word aligned.
module npc_sel
    import cpu_pkg::*;
(
    input  logic        jr,
    input  logic        jmp,
    input  logic        jal,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        zero,
    input  logic [31:0] read_data_1,
    input  logic [31:0] addr_result,
    input  logic [31:0] opcplus4,
    input  logic [25:0] instr_index,
    output logic [31:0] next_pc
);

    logic [31:0] sel_s;

    // priority selection of the raw next-PC candidate
    always_comb begin
        sel_s = opcplus4;
        if (jr) begin
            sel_s = read_data_1;
        end else if (jmp || jal) begin
            sel_s = jump_target(opcplus4, instr_index);
        end else if ((branch && zero) || (nbranch && !zero)) begin
            sel_s = addr_result;
        end else begin
            sel_s = opcplus4;
        end
    end

    assign next_pc = {sel_s[31:2], 2'b00};

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: FETCH -> ISSUE -> (FETCH | HALT) sequencer with PC,
// latched instruction and link value. Define IFU_TIMEOUT_EN for the fetch watchdog.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               Instruction,
    output logic [31:0]               opcplus4,
    output logic                      instr_valid,
    input  logic                      stall,
    input  logic                      Branch,
    input  logic                      nBranch,
    input  logic                      Jmp,
    input  logic                      Jal,
    input  logic                      Jr,
    input  logic                      Zero,
    input  logic [31:0]               Addr_result,
    input  logic [31:0]               Read_data_1,
    input  logic                      halt,
    output logic                      fetch_err
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc4_q, opc4_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc_s;

`ifdef IFU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    npc_sel u_npc_sel (
        .jr          (Jr),
        .jmp         (Jmp),
        .jal         (Jal),
        .branch      (Branch),
        .nbranch     (nBranch),
        .zero        (Zero),
        .read_data_1 (Read_data_1),
        .addr_result (Addr_result),
        .opcplus4    (opc4_q),
        .instr_index (instr_q[25:0]),
        .next_pc     (next_pc_s)
    );

    // next-state and datapath update; req/valid are registered copies of the next state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        opc4_d  = opc4_q;
`ifdef IFU_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            FETCH: begin
                // req_q is low only in the launch cycle right after reset
                if (req_q && imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    opc4_d  = pc_q + 32'd4;
                    state_d = ISSUE;
`ifdef IFU_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (req_q && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else if (req_q) begin
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end else begin
                    state_d = FETCH;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_d    = next_pc_s;
                    state_d = halt ? HALT : FETCH;
`ifdef IFU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = ISSUE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        req_d   = (state_d == FETCH);
        valid_d = (state_d == ISSUE);
    end

    // state and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            opc4_q  <= 32'h0000_0000;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            opc4_q  <= opc4_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

`ifdef IFU_TIMEOUT_EN
    // fetch watchdog counter and sticky error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign Instruction    = instr_q;
    assign opcplus4       = opc4_q;
    assign instr_valid    = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; the watchdog scenario
// is exercised when IFU_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_JR   = 6'b100000;
    localparam logic [5:0] C_JMP  = 6'b010000;
    localparam logic [5:0] C_JAL  = 6'b001000;
    localparam logic [5:0] C_BR   = 6'b000100;
    localparam logic [5:0] C_NBR  = 6'b000010;
    localparam logic [5:0] C_Z    = 6'b000001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instruction, opcplus4;
    logic        instr_valid, fetch_err;
    logic        stall = 1'b0, halt = 1'b0;
    logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, Zero = 1'b0;
    logic [31:0] Addr_result = 32'h0, Read_data_1 = 32'h0;
    int          n_checks = 0;
    int          n_pass   = 0;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .imem        (imem_bus.master),
        .Instruction (Instruction),
        .opcplus4    (opcplus4),
        .instr_valid (instr_valid),
        .stall       (stall),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Zero        (Zero),
        .Addr_result (Addr_result),
        .Read_data_1 (Read_data_1),
        .halt        (halt),
        .fetch_err   (fetch_err)
    );

    always #5 clock = ~clock;

    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(input string tag);
        int i;
        i = 0;
        while (imem_bus.imem_req !== 1'b1 && i < 20) begin
            @(negedge clock);
            i++;
        end
        n_checks++;
        if (imem_bus.imem_req !== 1'b1) $display("FAIL %s_req_wait: imem_req=%b required 1", tag, imem_bus.imem_req);
        else n_pass++;
    endtask

    // acknowledges one fetch and checks the resulting issue-cycle outputs
    task automatic fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] word);
        logic [31:0] exp_opc4;
        exp_opc4 = exp_addr + 32'd4;
        wait_req(tag);
        n_checks++;
        if (imem_bus.imem_addr !== exp_addr) $display("FAIL %s_addr: got %h required %h", tag, imem_bus.imem_addr, exp_addr);
        else n_pass++;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clock);
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        n_checks++;
        if (instr_valid !== 1'b1 || imem_bus.imem_req !== 1'b0)
            $display("FAIL %s_issue: valid=%b req=%b required 1/0", tag, instr_valid, imem_bus.imem_req);
        else n_pass++;
        n_checks++;
        if (Instruction !== word) $display("FAIL %s_instr: got %h required %h", tag, Instruction, word);
        else n_pass++;
        n_checks++;
        if (opcplus4 !== exp_opc4) $display("FAIL %s_opc4: got %h required %h", tag, opcplus4, exp_opc4);
        else n_pass++;
    endtask

    task automatic issue(input logic [5:0] ctl, input logic [31:0] rd1, input logic [31:0] ares);
        {Jr, Jmp, Jal, Branch, nBranch, Zero} = ctl;
        Read_data_1 = rd1;
        Addr_result = ares;
        @(negedge clock);
        {Jr, Jmp, Jal, Branch, nBranch, Zero} = C_NONE;
        Read_data_1 = 32'h0;
        Addr_result = 32'h0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL rst_ctrl: req=%b valid=%b required 0/0", imem_bus.imem_req, instr_valid);
        else n_pass++;
        n_checks++;
        if (Instruction !== 32'h0 || opcplus4 !== 32'h0 || fetch_err !== 1'b0)
            $display("FAIL rst_data: instr=%h opc4=%h err=%b required 0", Instruction, opcplus4, fetch_err);
        else n_pass++;
        n_checks++;
        if (imem_bus.imem_addr !== RESET_PC_DEFAULT) $display("FAIL rst_pc: got %h required %h", imem_bus.imem_addr, RESET_PC_DEFAULT);
        else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (imem_bus.imem_req !== 1'b1) $display("FAIL rst_restart: req=%b required 1", imem_bus.imem_req);
        else n_pass++;
    endtask

    task automatic test_basic();
        fetch("basic", 32'h0, 32'h2008_0005);
        issue(C_NONE, 32'h0, 32'h0);
        n_checks++;
        if (imem_bus.imem_addr !== 32'h4 || instr_valid !== 1'b0 || imem_bus.imem_req !== 1'b1)
            $display("FAIL basic_next: addr=%h valid=%b req=%b required 00000004/0/1", imem_bus.imem_addr, instr_valid, imem_bus.imem_req);
        else n_pass++;
    endtask

    task automatic test_branch();
        fetch("br0", 32'h4, 32'h0);
        issue(C_JR, 32'h10, 32'h0);
        fetch("br1", 32'h10, 32'h1000_0003);
        issue(C_BR | C_Z, 32'h0, 32'h40);
        fetch("br_taken", 32'h40, 32'h0);
        issue(C_JR, 32'h10, 32'h0);
        fetch("br2", 32'h10, 32'h1000_0003);
        issue(C_BR, 32'h0, 32'h40);
        fetch("br_not_taken", 32'h14, 32'h1400_0002);
        issue(C_NBR, 32'h0, 32'h83);
        fetch("bne_taken_align", 32'h80, 32'h1400_0002);
        issue(C_NBR | C_Z, 32'h0, 32'h200);
        fetch("bne_not_taken", 32'h84, 32'h0);
        issue(C_NONE, 32'h0, 32'h0);
    endtask

    task automatic test_jump();
        pulse_reset();
        fetch("jal", 32'h0, 32'h0C00_0010);
        issue(C_JAL, 32'h0, 32'h0);
        fetch("jal_target", 32'h40, 32'h0C00_0010);
        issue(C_JR | C_JAL, 32'h88, 32'h0);
        fetch("jr_wins", 32'h88, 32'h0800_0020);
        issue(C_JMP, 32'h0, 32'h0);
        fetch("j_target", 32'h80, 32'h0);
        issue(C_JR, 32'hFFFF_FFFF, 32'h0);
        fetch("wrap", 32'hFFFF_FFFC, 32'h0);
        n_checks++;
        if (opcplus4 !== 32'h0) $display("FAIL wrap_opc4: got %h required 00000000", opcplus4);
        else n_pass++;
        issue(C_NONE, 32'h0, 32'h0);
        fetch("wrap_next", 32'h0, 32'h0);
        issue(C_JR, 32'h8000_0003, 32'h0);
        fetch("j_region", 32'h8000_0000, 32'h0800_0004);
        issue(C_JMP, 32'h0, 32'h0);
        fetch("j_region_target", 32'h8000_0010, 32'h0);
        issue(C_NONE, 32'h0, 32'h0);
    endtask

    task automatic test_stall();
        int valid_cycles;
        fetch("stall", 32'h8000_0014, 32'h1234_5678);
        valid_cycles = 1;
        stall = 1'b1;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (instr_valid === 1'b1) valid_cycles++;
            n_checks++;
            if (Instruction !== 32'h1234_5678 || imem_bus.imem_req !== 1'b0 || opcplus4 !== 32'h8000_0018)
                $display("FAIL stall_hold: instr=%h req=%b opc4=%h required 12345678/0/80000018", Instruction, imem_bus.imem_req, opcplus4);
            else n_pass++;
        end
        stall = 1'b0;
        imem_bus.imem_ack = 1'b0;
        @(negedge clock);
        n_checks++;
        if (valid_cycles !== 4) $display("FAIL stall_valid_len: got %0d required 4", valid_cycles);
        else n_pass++;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_bus.imem_addr !== 32'h8000_0018)
            $display("FAIL stall_release: valid=%b addr=%h required 0/80000018", instr_valid, imem_bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_halt();
        halt = 1'b1;
        fetch("halt_fetch", 32'h8000_0018, 32'hCAFE_0001);
        @(negedge clock);
        halt = 1'b0;
        imem_bus.imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_checks++;
            if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || Instruction !== 32'hCAFE_0001 || imem_bus.imem_addr !== 32'h8000_001C)
                $display("FAIL halt_hold: req=%b valid=%b instr=%h addr=%h required 0/0/cafe0001/8000001c",
                         imem_bus.imem_req, instr_valid, Instruction, imem_bus.imem_addr);
            else n_pass++;
        end
        imem_bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        pulse_reset();
        fetch("rm0", 32'h0, 32'h0);
        issue(C_JR, 32'h20, 32'h0);
        n_checks++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h20)
            $display("FAIL rm_pre: req=%b addr=%h required 1/00000020", imem_bus.imem_req, imem_bus.imem_addr);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || Instruction !== 32'h0 || opcplus4 !== 32'h0)
            $display("FAIL rm_async: req=%b valid=%b instr=%h opc4=%h required all 0", imem_bus.imem_req, instr_valid, Instruction, opcplus4);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RESET_PC_DEFAULT)
            $display("FAIL rm_restart: req=%b addr=%h required 1/%h", imem_bus.imem_req, imem_bus.imem_addr, RESET_PC_DEFAULT);
        else n_pass++;
    endtask

    task automatic test_timeout();
`ifdef IFU_TIMEOUT_EN
        pulse_reset();
        repeat (254) @(negedge clock);
        n_checks++;
        if (fetch_err !== 1'b0 || imem_bus.imem_req !== 1'b1)
            $display("FAIL to_early: err=%b req=%b required 0/1", fetch_err, imem_bus.imem_req);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (fetch_err !== 1'b1 || imem_bus.imem_req !== 1'b0)
            $display("FAIL to_fire: err=%b req=%b required 1/0", fetch_err, imem_bus.imem_req);
        else n_pass++;
        imem_bus.imem_ack = 1'b1;
        repeat (3) @(negedge clock);
        imem_bus.imem_ack = 1'b0;
        n_checks++;
        if (fetch_err !== 1'b1 || imem_bus.imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL to_halt: err=%b req=%b valid=%b required 1/0/0", fetch_err, imem_bus.imem_req, instr_valid);
        else n_pass++;
`else
        pulse_reset();
        repeat (300) @(negedge clock);
        n_checks++;
        if (fetch_err !== 1'b0 || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0)
            $display("FAIL no_timeout: err=%b req=%b addr=%h required 0/1/00000000", fetch_err, imem_bus.imem_req, imem_bus.imem_addr);
        else n_pass++;
        fetch("late_ack", 32'h0, 32'h2008_0005);
`endif
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_branch();
        test_jump();
        test_stall();
        test_halt();
        test_reset_mid_fetch();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
